// File: rtl/apb_addr_map_regs.sv
// APB completer holding the software-writable per-slave address map, enable mask, lock and config-error status.
// Access latency is WAIT_STATES+1 cycles after SETUP; the completer stalls the requester only by holding pready low.
module apb_addr_map_regs #(
  parameter int          SLAVE_NUM    = 4,
  parameter int          WAIT_STATES  = 0,
  parameter logic [31:0] RESET_BASE   = 32'h0000_0000,
  parameter logic [31:0] RESET_SIZE   = 32'h0000_1000,
  parameter int          PRIV_WR_ONLY = 1
) (
  input  logic                   pclk,
  input  logic                   preset_n,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [31:0]            paddr,
  input  logic [31:0]            pwdata,
  input  logic [3:0]             pstrb,
  input  logic [2:0]             pprot,
  output logic                   pready,
  output logic [31:0]            prdata,
  output logic                   pslverr,
  output logic [32*SLAVE_NUM-1:0] map_start,
  output logic [32*SLAVE_NUM-1:0] map_end,
  output logic [SLAVE_NUM-1:0]   map_en
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [31:0]          start_q [SLAVE_NUM];
  logic [31:0]          start_d [SLAVE_NUM];
  logic [31:0]          end_q   [SLAVE_NUM];
  logic [31:0]          end_d   [SLAVE_NUM];
  logic [SLAVE_NUM-1:0] en_q, en_d;
  logic                 lock_q, lock_d;
  logic [SLAVE_NUM-1:0] cfg_err;

  logic [7:0]  off;
  logic [3:0]  idx;
  logic        hit_se, is_ctrl, is_en, is_stat, err, wr_commit;
  logic [31:0] rd_dat, en_merged;
  logic        unused_prot;

  assign unused_prot = ^pprot[2:1];

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++)
      if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
    return r;
  endfunction

  always_comb begin
    off     = paddr[7:0];
    idx     = off[6:3];
    hit_se  = !off[7] && (int'(idx) < SLAVE_NUM);
    is_ctrl = (off == 8'h80);
    is_en   = (off == 8'h84);
    is_stat = (off == 8'h88);
    err = (paddr[1:0] != 2'b00) || (paddr[31:8] != 24'd0)
       || !(hit_se || is_ctrl || is_en || is_stat)
       || (pwrite && is_stat)
       || (pwrite && lock_q && (hit_se || is_en))
       || (pwrite && (PRIV_WR_ONLY != 0) && !pprot[0]);
  end

  assign pready    = (state_q == ACCESS) && (cnt_q == 3'(WAIT_STATES));
  assign wr_commit = pready && psel && pwrite && !err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:   if (psel && !penable) state_d = SETUP;
      SETUP: begin
        if (!psel) state_d = IDLE;
        else if (penable) begin
          state_d = ACCESS;
          cnt_d   = 3'd0;
        end
      end
      ACCESS: begin
        if (!psel) state_d = IDLE;
        else if (pready) state_d = penable ? IDLE : SETUP;
        else cnt_d = cnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_d   = start_q;
    end_d     = end_q;
    en_d      = en_q;
    lock_d    = lock_q;
    en_merged = merge(32'(en_q), pwdata, pstrb);
    if (wr_commit) begin
      for (int i = 0; i < SLAVE_NUM; i++) begin
        if (hit_se && idx == 4'(i)) begin
          if (paddr[2]) end_d[i]   = merge(end_q[i], pwdata, pstrb);
          else          start_d[i] = merge(start_q[i], pwdata, pstrb);
        end
      end
      if (is_en) en_d = en_merged[SLAVE_NUM-1:0];
      // LOCK can only be set; a zero write is ignored
      if (is_ctrl && pstrb[0] && pwdata[0]) lock_d = 1'b1;
    end
  end

  always_comb begin
    rd_dat = 32'd0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      cfg_err[i]           = start_q[i] > end_q[i];
      map_start[32*i +: 32] = start_q[i];
      map_end[32*i +: 32]   = end_q[i];
      if (hit_se && idx == 4'(i)) rd_dat = paddr[2] ? end_q[i] : start_q[i];
    end
    if (is_ctrl) rd_dat[0] = lock_q;
    if (is_en)   rd_dat[SLAVE_NUM-1:0] = en_q;
    if (is_stat) rd_dat[SLAVE_NUM-1:0] = cfg_err;
    map_en  = en_q & ~cfg_err;
    prdata  = (pready && !pwrite && !err) ? rd_dat : 32'd0;
    pslverr = pready && err;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      for (int i = 0; i < SLAVE_NUM; i++) begin
        start_q[i] <= RESET_BASE + 32'(i) * RESET_SIZE;
        end_q[i]   <= RESET_BASE + 32'(i + 1) * RESET_SIZE - 32'd1;
      end
      en_q   <= '1;
      lock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      end_q   <= end_d;
      en_q    <= en_d;
      lock_q  <= lock_d;
    end
  end

endmodule

// File: tb/tb_apb_addr_map_regs.sv
// Bench for apb_addr_map_regs: one instance with no wait states, one with three, sharing the APB bus.
module tb_apb_addr_map_regs;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         psel0 = 1'b0, psel3 = 1'b0;
  logic         penable = 1'b0, pwrite = 1'b0;
  logic [31:0]  paddr = '0, pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic [2:0]   pprot = '0;

  logic         pready0, pslverr0, pready3, pslverr3;
  logic [31:0]  prdata0, prdata3;
  logic [127:0] map_start0, map_end0, map_start3, map_end3;
  logic [3:0]   map_en0, map_en3;

  int n_checks = 0;
  int n_fail   = 0;
  int last_lat = 0;
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  apb_addr_map_regs #(.SLAVE_NUM(4), .WAIT_STATES(0)) u0 (
    .pclk(clk), .preset_n(rst_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
    .map_start(map_start0), .map_end(map_end0), .map_en(map_en0));

  apb_addr_map_regs #(.SLAVE_NUM(4), .WAIT_STATES(3)) u3 (
    .pclk(clk), .preset_n(rst_n), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready3), .prdata(prdata3), .pslverr(pslverr3),
    .map_start(map_start3), .map_end(map_end3), .map_en(map_en3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_psel(input int inst, input logic v);
    if (inst == 3) psel3 = v;
    else           psel0 = v;
  endtask

  task automatic apb(input int inst, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [2:0] prot, input logic [31:0] exp_rd,
                     input bit exp_err, input string tag);
    logic [32:0] e;
    logic [31:0] got_rd;
    logic        got_err;
    logic        pr;
    bit          done;
    int          n;
    sb_q.push_back({exp_err, exp_rd});
    @(posedge clk); #1;
    set_psel(inst, 1'b1);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    done = 0; n = 0; got_rd = '0; got_err = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      pr = (inst == 3) ? pready3 : pready0;
      if (pr) begin
        got_rd  = (inst == 3) ? prdata3 : prdata0;
        got_err = (inst == 3) ? pslverr3 : pslverr0;
        done    = 1;
      end
    end
    last_lat = n;
    @(posedge clk); #1;
    set_psel(inst, 1'b0);
    penable = 1'b0;
    e = sb_q.pop_front();
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      check({tag, "_err"}, 32'(got_err), 32'(e[32]));
      if (!wr) check({tag, "_rd"}, got_rd, e[31:0]);
    end
  endtask

  task automatic rd(input int inst, input logic [31:0] addr, input logic [31:0] exp,
                    input bit exp_err, input string tag);
    apb(inst, 1'b0, addr, 32'd0, 4'h0, 3'b001, exp, exp_err, tag);
  endtask

  task automatic wr(input int inst, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [2:0] prot, input bit exp_err, input string tag);
    apb(inst, 1'b1, addr, data, strb, prot, 32'd0, exp_err, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_pready",  32'(pready0), 32'd0);
    check("rst_prdata",  prdata0, 32'd0);
    check("rst_pslverr", 32'(pslverr0), 32'd0);
    check("rst_map_en",  32'(map_en0), 32'hF);
    check("rst_start1",  map_start0[63:32], 32'h0000_1000);
    check("rst_end3",    map_end0[127:96], 32'h0000_3FFF);

    rd(0, 32'h00, 32'h0000_0000, 0, "rd_start0");
    check("lat_ws0", 32'(last_lat), 32'd2);
    rd(0, 32'h04, 32'h0000_0FFF, 0, "rd_end0");
    rd(0, 32'h18, 32'h0000_3000, 0, "rd_start3");
    rd(0, 32'h1C, 32'h0000_3FFF, 0, "rd_end3");

    wr(0, 32'h08, 32'h1234_5678, 4'b0101, 3'b001, 0, "wr_strb");
    rd(0, 32'h08, 32'h0034_1078, 0, "rd_strb");

    wr(0, 32'h08, 32'h9000_0000, 4'hF, 3'b001, 0, "wr_start1");
    rd(0, 32'h88, 32'h0000_0002, 0, "status_bad");
    check("map_en_bad", 32'(map_en0), 32'hD);
    check("map_start1", map_start0[63:32], 32'h9000_0000);
    wr(0, 32'h0C, 32'h9000_FFFF, 4'hF, 3'b001, 0, "wr_end1");
    rd(0, 32'h88, 32'h0000_0000, 0, "status_ok");
    check("map_en_ok", 32'(map_en0), 32'hF);
    check("map_end1",  map_end0[63:32], 32'h9000_FFFF);

    wr(0, 32'h84, 32'h0000_0005, 4'hF, 3'b001, 0, "wr_en");
    check("map_en_5", 32'(map_en0), 32'h5);
    wr(0, 32'h84, 32'h0000_000F, 4'h1, 3'b001, 0, "wr_en_back");
    wr(0, 32'h10, 32'hDEAD_BEEF, 4'h0, 3'b001, 0, "wr_nostrb");
    rd(0, 32'h10, 32'h0000_2000, 0, "rd_nostrb");

    rd(0, 32'h02, 32'h0, 1, "err_misalign");
    rd(0, 32'h20, 32'h0, 1, "err_slave4");
    rd(0, 32'h104, 32'h0, 1, "err_highaddr");
    rd(0, 32'h8C, 32'h0, 1, "err_undecoded");
    wr(0, 32'h88, 32'h0, 4'hF, 3'b001, 1, "err_wr_status");
    wr(0, 32'h84, 32'h0, 4'hF, 3'b000, 1, "err_unpriv");
    rd(0, 32'h84, 32'h0000_000F, 0, "rd_en_after_unpriv");

    wr(0, 32'h80, 32'h1, 4'hF, 3'b001, 0, "wr_lock");
    rd(0, 32'h80, 32'h1, 0, "rd_lock");
    wr(0, 32'h00, 32'hFFFF_FFFF, 4'hF, 3'b001, 1, "err_locked_start");
    rd(0, 32'h00, 32'h0, 0, "rd_start0_locked");
    wr(0, 32'h84, 32'h0, 4'hF, 3'b001, 1, "err_locked_en");
    wr(0, 32'h80, 32'h0, 4'hF, 3'b001, 0, "wr_ctrl0");
    rd(0, 32'h80, 32'h1, 0, "rd_lock_sticky");

    rd(3, 32'h04, 32'h0000_0FFF, 0, "ws3_rd");
    check("lat_ws3", 32'(last_lat), 32'd5);

    // abort in the second access cycle of a wait-stated write
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00;
    pwdata = 32'hAAAA_0000; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 psel3 = 1'b0; penable = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (pready3) seen++;
    end
    check("abort_pready", 32'(seen), 32'd0);
    rd(3, 32'h00, 32'h0, 0, "abort_nowrite");

    wr(3, 32'h84, 32'h3, 4'hF, 3'b001, 0, "ws3_wr_en");
    check("ws3_map_en3", 32'(map_en3), 32'h3);
    wr(3, 32'h10, 32'h1111_0000, 4'hF, 3'b001, 0, "ws3_wr_start2");
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00;
    pwdata = 32'h1234_0000; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("rst_mid_pready", 32'(pready3), 32'd0);
    psel3 = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_map_en",  32'(map_en3), 32'hF);
    check("rst_mid_start0",  map_start3[31:0], 32'h0);
    check("rst_mid_start2",  map_start3[95:64], 32'h0000_2000);
    check("rst_mid_end1",    map_end3[63:32], 32'h0000_1FFF);
    rd(3, 32'h00, 32'h0, 0, "rst_mid_rd_start0");
    rd(3, 32'h84, 32'hF, 0, "rst_mid_rd_en");
    rd(0, 32'h80, 32'h0, 0, "rst_lock_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_addr_map_regs.md
Name: apb_addr_map_regs

Overview:
- APB3/APB4 completer holding the bridge's per-slave address map (START/END per slave), a per-slave enable mask, a lock bit and a config-error status.
- Unlike the fixed, read-only map block, the map here is software-writable with byte strobes.
- Adds configurable wait states, privilege-checked writes and a lock.
- The bridge's address decoder consumes the flattened map outputs.

Parameters:
- SLAVE_NUM, 4, number of APB slaves mapped; legal range 1..16.
- WAIT_STATES, 0, access-phase cycles before PREADY; legal range 0..7.
- RESET_BASE, 32'h0000_0000, reset START of slave 0.
- RESET_SIZE, 32'h0000_1000, reset window size per slave.
- PRIV_WR_ONLY, 1, if 1 a write with pprot[0]=0 is an error.

Ports:
- pclk  in  1  clock
- preset_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  1=write
- paddr  in  32  byte address
- pwdata  in  32  write data
- pstrb  in  4  write byte strobes
- pprot  in  3  protection; only bit0 (privileged) is used
- pready  out  1  transfer complete
- prdata  out  32  read data
- pslverr  out  1  transfer error
- map_start  out  32*SLAVE_NUM  START_i at bits [32i+31:32i]
- map_end  out  32*SLAVE_NUM  END_i at bits [32i+31:32i]
- map_en  out  SLAVE_NUM  EN[i] & ~cfg_err[i]

Behaviour:
- Register map (decode paddr[7:0]):
  - START_i at 8i, END_i at 8i+4, for i < SLAVE_NUM.
  - CTRL at 0x80: bit0 LOCK, write-1-only, sticky until reset.
  - EN at 0x84: bits [SLAVE_NUM-1:0], RW.
  - STATUS at 0x88: cfg_err[SLAVE_NUM-1:0], RO.
  - Unused bits read 0.
- Reset values (async, on preset_n low):
  - START_i = RESET_BASE + i*RESET_SIZE; END_i = START_i + RESET_SIZE - 1 (32-bit wrap).
  - EN all ones; LOCK 0.
  - pready 0, prdata 0, pslverr 0.
- cfg_err[i] = START_i > END_i, unsigned. It is combinational, so it updates the cycle after any write.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE -> SETUP on psel & ~penable.
  - SETUP -> ACCESS on psel & penable; wait counter cleared.
  - In ACCESS, counter increments each cycle while below WAIT_STATES.
  - pready = (state==ACCESS) & (cnt==WAIT_STATES), combinational from registered state. With WAIT_STATES=0 it is high in the first access cycle.
  - On the pready cycle: go to SETUP if psel & ~penable (back-to-back), else IDLE.
  - psel low in SETUP or ACCESS aborts: go to IDLE, no write, no outputs.
- prdata and pslverr are valid only while pready=1 and read 0 otherwise. pslverr is 0 on reads unless an error condition below applies.
- Error conditions; any one sets pslverr=1 on the pready cycle:
  - paddr[1:0] != 0
  - paddr[31:8] != 0
  - undecoded offset, including START_i/END_i with i >= SLAVE_NUM
  - write to STATUS
  - write to START/END/EN while LOCK=1
  - write with pprot[0]=0 while PRIV_WR_ONLY=1
- An errored write changes no state. An errored read returns prdata 0.
- Write commit:
  - Occurs on the pready cycle, no error, pwrite=1.
  - Byte lane k is updated only if pstrb[k]=1. pstrb=0 is a legal no-op.
  - Writing CTRL with bit0=0 leaves LOCK unchanged. CTRL remains writable while locked.
- Read data is sampled combinationally from register state on the pready cycle. A write and its next read are separated by at least one SETUP cycle, so no hazard arises.
- Reset asserted mid-transfer: immediate return to IDLE, all registers to reset values, no partial write.

Test Plan:
- Reset, SLAVE_NUM=4 -> read 0x00/0x04/0x18/0x1C returns 0x0000_0000/0x0000_0FFF/0x0000_3000/0x0000_3FFF; map_en=4'hF.
- Privileged write 0x08=0x1234_5678 with pstrb=4'b0101 -> readback 0x0034_1078 (old 0x0000_1000 in lanes 1,3); pslverr=0.
- Write START_1=0x9000_0000 (> END_1=0x0000_1FFF) -> STATUS=0x2, map_en=4'hD; write END_1=0x9000_FFFF -> STATUS=0, map_en=4'hF.
- Write CTRL=1, then write 0x00=0xFFFF_FFFF -> pslverr=1, START_0 still 0; write 0x80=0 -> LOCK stays 1.
- Errors:
  - read 0x02 -> pslverr=1, prdata=0
  - read 0x20 -> pslverr=1, prdata=0
  - write 0x88 -> pslverr=1
  - write pprot=3'b000 -> pslverr=1, no update
- WAIT_STATES=3: pready rises exactly 4 cycles after ACCESS entry. A second run deasserts psel in access cycle 2, after which the FSM is IDLE and no write occurs. A further run asserts preset_n=0 mid-write; all registers return to reset values.
